// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W      = 25;  // 64 MB of 16-bit words
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_MAX_PEND    = 8;   // outstanding reads, power of 2
  localparam int DEF_GRANT_LIMIT = 4;   // accepted transfers per tenure

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  // Master identifier; this is also the tag stored per outstanding read.
  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

  // Ownership state that belongs to a given master.
  function automatic arb_state_e own_state(input owner_t id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO: remembers which master issued each outstanding read so that
// in-order read data from the controller can be steered back to it.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_PEND
) (
  input  logic                   clk_50,
  input  logic                   reset_n,
  input  logic                   push,
  input  owner_t                 push_id,
  input  logic                   pop,
  output owner_t                 head_id,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  owner_t        mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == FULL_CNT);
  assign head_id = mem_q[rd_ptr_q[AW-1:0]];

  // A pop on empty is ignored; a push while full is legal only with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Advance the pointers for the accepted push/pop of this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + CW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + CW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Tag storage write port.
  // NOTE: storage is not reset; the reset pointers make every slot invalid.
  always_ff @(posedge clk_50) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single SDRAM controller.
// Grants are held for up to GRANT_LIMIT accepted transfers, alternate on
// contention, and read responses are routed back through a tag FIFO.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_PEND    = DEF_MAX_PEND,
  parameter int GRANT_LIMIT = DEF_GRANT_LIMIT
) (
  input  logic                      clk_50,
  input  logic                      reset_n,
  // master 0
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [1:0]                m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [1:0]                m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  // SDRAM controller side
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_read,
  output logic                      s_write,
  output logic [DATA_W-1:0]         s_writedata,
  output logic [1:0]                s_byteenable,
  input  logic                      s_waitrequest,
  input  logic [DATA_W-1:0]         s_readdata,
  input  logic                      s_readdatavalid,
  // status
  output logic [1:0]                grant,
  output logic [$clog2(MAX_PEND):0] pend_cnt,
  output logic                      err_orphan
);

  localparam int TW = $clog2(GRANT_LIMIT + 1);
  localparam logic [TW-1:0] LAST_BEAT = TW'(GRANT_LIMIT - 1);

  arb_state_e    state_q, state_d;
  owner_t        last_owner_q, last_owner_d;
  logic [TW-1:0] tenure_q, tenure_d;
  logic          err_orphan_q, err_orphan_d;

  logic   m0_req, m1_req;
  logic   owner_req, other_req;
  owner_t owner;
  logic   pend_full, pend_empty;
  logic   accept, read_accept, rsp_pop;
  owner_t head_id;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // Decode the current owner and whether each side is asking for the bus.
  always_comb begin
    owner     = OWNER_M0;
    owner_req = 1'b0;
    other_req = 1'b0;
    case (state_q)
      ST_OWN0: begin owner = OWNER_M0; owner_req = m0_req; other_req = m1_req; end
      ST_OWN1: begin owner = OWNER_M1; owner_req = m1_req; other_req = m0_req; end
      default: ;
    endcase
  end

  // Steer the owner's command to the controller; reads stall while the tag FIFO is full.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      ST_OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~pend_full;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest | (m0_read & pend_full);
      end
      ST_OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~pend_full;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest | (m1_read & pend_full);
      end
      default: ;
    endcase
  end

  assign accept      = (s_read | s_write) & ~s_waitrequest;
  assign read_accept = s_read & ~s_waitrequest;

  // Next-state logic: arbitration from IDLE, tenure limit, and the hold rule
  // (an owner with an unaccepted command keeps the bus).
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    tenure_d     = tenure_q;
    err_orphan_d = err_orphan_q | (s_readdatavalid & pend_empty);
    case (state_q)
      ST_IDLE: begin
        tenure_d = '0;
        if (m0_req & m1_req) begin
          state_d      = own_state(~last_owner_q);
          last_owner_d = ~last_owner_q;
        end else if (m0_req) begin
          state_d      = ST_OWN0;
          last_owner_d = OWNER_M0;
        end else if (m1_req) begin
          state_d      = ST_OWN1;
          last_owner_d = OWNER_M1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!owner_req) begin
          tenure_d = '0;
          if (other_req) begin
            state_d      = own_state(~owner);
            last_owner_d = ~owner;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept) begin
          if (tenure_q == LAST_BEAT) begin
            tenure_d = '0;
            if (other_req) begin
              state_d      = own_state(~owner);
              last_owner_d = ~owner;
            end
          end else begin
            tenure_d = tenure_q + TW'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tenure_d = '0;
      end
    endcase
  end

  // Arbiter state registers; grant is the state register itself.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_M1;
      tenure_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      tenure_q     <= tenure_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign grant      = state_q;
  assign err_orphan = err_orphan_q;

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .push    (read_accept),
    .push_id (owner),
    .pop     (s_readdatavalid),
    .head_id (head_id),
    .full    (pend_full),
    .empty   (pend_empty),
    .count   (pend_cnt)
  );

  // Responses follow the tag at the FIFO head, independent of the current grant.
  assign rsp_pop          = s_readdatavalid & ~pend_empty;
  assign m0_readdatavalid = rsp_pop & (head_id == OWNER_M0);
  assign m1_readdatavalid = rsp_pop & (head_id == OWNER_M1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: IDLE-arbitration vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// transaction-level model of two masters and an in-order SDRAM controller.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam logic [DW-1:0] MASK = 16'h5A5A;

  logic          clk_50 = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [1:0]    grant;
  logic [3:0]    pend_cnt;
  logic          err_orphan;

  sdram_port_arbiter dut (
    .clk_50           (clk_50),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .grant            (grant),
    .pend_cnt         (pend_cnt),
    .err_orphan       (err_orphan)
  );

  always #10 clk_50 = ~clk_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model state ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic          owner;
  } ret_t;

  logic          mrd [2];
  logic          mwr [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdata [2];
  logic [1:0]    mbe [2];
  int            mseq [2];
  int            issued_rd [2];
  int            returned_rd [2];
  ret_t          ret_q [$];
  int            acc_log [$];

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    for (int n = 0; n < 2; n++) begin
      mrd[n] = 0; mwr[n] = 0; maddr[n] = '0; mwdata[n] = '0; mbe[n] = '0;
      issued_rd[n] = 0; returned_rd[n] = 0;
    end
    ret_q.delete();
    acc_log.delete();
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk_50);
    #1 reset_n = 1;
  endtask

  task automatic drive_masters();
    m0_read = mrd[0]; m0_write = mwr[0]; m0_address = maddr[0];
    m0_writedata = mwdata[0]; m0_byteenable = mbe[0];
    m1_read = mrd[1]; m1_write = mwr[1]; m1_address = maddr[1];
    m1_writedata = mwdata[1]; m1_byteenable = mbe[1];
  endtask

  // One master read held until accepted (bounded), then released.
  task automatic do_read(input int id, input logic [AW-1:0] addr);
    bit acc = 0;
    if (id == 0) begin m0_read = 1; m0_address = addr; end
    else         begin m1_read = 1; m1_address = addr; end
    for (int k = 0; k < 20 && !acc; k++) begin
      #4;
      if ((id == 0) ? !m0_waitrequest : !m1_waitrequest) begin
        acc = 1;
        check("rd_addr", s_address, addr);
      end
      step();
    end
    m0_read = 0; m1_read = 0;
    check("rd_accepted", acc, 1);
  endtask

  // Randomized traffic. Each master holds a command until it sees
  // waitrequest low; the controller accepts at random and returns read
  // data in order, some cycles later, as addr[15:0]^MASK.
  task automatic run_traffic(input int cycles, input int p_req, input int p_wait,
                             input int p_ret, input bit stream);
    bit         hold_pend = 0;
    logic [1:0] hold_grant = '0;
    logic       acc [2];
    logic       s_acc;
    ret_t       r;
    for (int c = 0; c < cycles; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!mrd[n] && !mwr[n] && (int'($urandom_range(99)) < p_req)) begin
          mseq[n]++;
          maddr[n] = AW'((n << 12) | (mseq[n] & 'hFFF));
          mbe[n]   = 2'($urandom_range(3));
          if (stream || $urandom_range(1) == 0) mrd[n] = 1;
          else begin mwr[n] = 1; mwdata[n] = DW'($urandom); end
        end
      end
      drive_masters();
      s_waitrequest = (int'($urandom_range(99)) < p_wait);
      if (ret_q.size() > 0 && int'($urandom_range(99)) < p_ret) begin
        s_readdatavalid = 1; s_readdata = ret_q[0].data;
      end else begin
        s_readdatavalid = 0; s_readdata = DW'($urandom);
      end
      #4;
      check("pend_cnt", pend_cnt, ret_q.size());
      if (hold_pend) check("hold_grant", grant, hold_grant);
      acc[0] = (mrd[0] | mwr[0]) & ~m0_waitrequest;
      acc[1] = (mrd[1] | mwr[1]) & ~m1_waitrequest;
      s_acc  = (s_read | s_write) & ~s_waitrequest;
      check("single_accept", acc[0] & acc[1], 0);
      check("accept_match", s_acc, acc[0] | acc[1]);
      hold_pend  = (grant == 2'b01 && (mrd[0] | mwr[0]) && !acc[0]) ||
                   (grant == 2'b10 && (mrd[1] | mwr[1]) && !acc[1]);
      hold_grant = grant;
      if (s_readdatavalid) begin
        r = ret_q.pop_front();
        check("rdv_m0", m0_readdatavalid, (r.owner == 1'b0));
        check("rdv_m1", m1_readdatavalid, (r.owner == 1'b1));
        check("readdata", r.owner ? m1_readdata : m0_readdata, r.data);
        returned_rd[r.owner]++;
      end else begin
        check("rdv_quiet", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
      end
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          check("acc_addr", s_address, maddr[n]);
          check("acc_kind", {s_read, s_write}, {mrd[n], mwr[n]});
          check("acc_be", s_byteenable, mbe[n]);
          if (mwr[n]) check("acc_wdata", s_writedata, mwdata[n]);
          if (mrd[n]) begin
            ret_q.push_back('{data: maddr[n][15:0] ^ MASK, owner: 1'(n)});
            issued_rd[n]++;
          end
          acc_log.push_back(n);
          mrd[n] = 0; mwr[n] = 0;
        end
      end
      step();
    end
  endtask

  // ---------------- IDLE arbitration vectors (from reset) ----------------
  typedef struct {
    logic       m0r, m0w, m1r, m1w, swait;
    logic [1:0] grant;
    logic       m0_wait, m1_wait, sr, sw;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [AW-1:0] exp_addr;
    vecs[0] = '{0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 2'b01, 0, 1, 1, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 2'b10, 1, 0, 0, 1};
    vecs[3] = '{1, 0, 1, 0, 0, 2'b01, 0, 1, 1, 0};
    vecs[4] = '{0, 1, 0, 0, 1, 2'b01, 1, 1, 0, 1};
    vecs[5] = '{0, 0, 1, 0, 1, 2'b10, 1, 1, 1, 0};
    vecs[6] = '{0, 1, 0, 1, 0, 2'b01, 0, 1, 0, 1};

    reset_n = 0;
    clear_inputs();
    #3;
    check("rst_grant", grant, 2'b00);
    check("rst_pend", pend_cnt, 0);
    check("rst_err", err_orphan, 0);
    check("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      m0_read = vecs[i].m0r; m0_write = vecs[i].m0w;
      m1_read = vecs[i].m1r; m1_write = vecs[i].m1w;
      s_waitrequest = vecs[i].swait;
      m0_address = 25'h123; m1_address = 25'h456;
      #4;
      check("idle_grant", grant, 2'b00);
      check("idle_cmd", {s_read, s_write}, 2'b00);
      check("idle_addr", s_address, 0);
      check("idle_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
      step();
      #4;
      exp_addr = (vecs[i].grant == 2'b01) ? 25'h123 : (vecs[i].grant == 2'b10) ? 25'h456 : '0;
      check("vec_grant", grant, vecs[i].grant);
      check("vec_wait", {m0_waitrequest, m1_waitrequest}, {vecs[i].m0_wait, vecs[i].m1_wait});
      check("vec_cmd", {s_read, s_write}, {vecs[i].sr, vecs[i].sw});
      check("vec_addr", s_address, exp_addr);
    end

    // m0 alone issues three writes with no controller stall.
    do_reset();
    m0_write = 1; m0_address = 25'h100; m0_writedata = 16'h1111; m0_byteenable = 2'b11;
    #4;
    check("w_idle_grant", grant, 2'b00);
    step();
    for (int k = 0; k < 3; k++) begin
      m0_address = 25'h100 + AW'(k); m0_writedata = DW'(16'h1111 * (k + 1));
      #4;
      check("w_grant", grant, 2'b01);
      check("w_wait", m0_waitrequest, 0);
      check("w_swrite", s_write, 1);
      check("w_addr", s_address, 25'h100 + k);
      check("w_data", s_writedata, 16'h1111 * (k + 1));
      step();
    end
    m0_write = 0;
    #4;
    check("w_drop_swrite", s_write, 0);
    step();
    #4;
    check("w_back_idle", grant, 2'b00);

    // last_owner: after m0 was served, simultaneous requests go to m1.
    do_reset();
    do_read(0, 25'h8);
    step();
    m0_read = 1; m1_read = 1;
    #4;
    check("lo_idle", grant, 2'b00);
    step();
    #4;
    check("lo_m1_wins", grant, 2'b10);
    m0_read = 0; m1_read = 0;

    // Eight reads fill the tag FIFO; the ninth stalls until the first return.
    do_reset();
    m0_read = 1; m0_address = 25'h40;
    step();
    for (int k = 0; k < 8; k++) begin
      #4;
      check("pf_accept", m0_waitrequest, 0);
      step();
    end
    #4;
    check("pf_cnt8", pend_cnt, 8);
    check("pf_sread0", s_read, 0);
    check("pf_wait1", m0_waitrequest, 1);
    step();
    #4;
    check("pf_still_stalled", s_read, 0);
    s_readdatavalid = 1; s_readdata = 16'hBEEF;
    #1;
    check("pf_rdv0", m0_readdatavalid, 1);
    check("pf_rdv1", m1_readdatavalid, 0);
    check("pf_rdata0", m0_readdata, 16'hBEEF);
    check("pf_rdata1", m1_readdata, 16'hBEEF);
    check("pf_pop_cycle_sread", s_read, 0);
    step();
    s_readdatavalid = 0;
    #4;
    check("pf_cnt7", pend_cnt, 7);
    check("pf_ninth_sread", s_read, 1);
    check("pf_ninth_wait", m0_waitrequest, 0);
    step();
    #4;
    check("pf_cnt8_again", pend_cnt, 8);
    m0_read = 0;

    // Interleaved reads; responses are steered by tag, not by grant.
    do_reset();
    do_read(0, 25'h10);
    do_read(1, 25'h20);
    do_read(0, 25'h30);
    #4;
    check("il_pend3", pend_cnt, 3);
    for (int k = 0; k < 3; k++) begin
      s_readdatavalid = 1; s_readdata = DW'(16'hA000 + k);
      #4;
      check("il_rdv0", m0_readdatavalid, (k != 1));
      check("il_rdv1", m1_readdatavalid, (k == 1));
      check("il_data", (k == 1) ? m1_readdata : m0_readdata, 16'hA000 + k);
      step();
    end
    s_readdatavalid = 0;
    #4;
    check("il_pend0", pend_cnt, 0);
    check("il_no_orphan", err_orphan, 0);

    // Orphan response: sticky error, nothing delivered.
    do_reset();
    s_readdatavalid = 1; s_readdata = 16'h1234;
    #4;
    check("or_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    step();
    s_readdatavalid = 0;
    #4;
    check("or_err", err_orphan, 1);
    check("or_pend", pend_cnt, 0);
    repeat (5) step();
    #4;
    check("or_sticky", err_orphan, 1);
    do_reset();
    #4;
    check("or_cleared", err_orphan, 0);

    // Reset with five reads outstanding and the controller stalling.
    do_reset();
    m0_read = 1; m0_address = 25'h77;
    step();
    repeat (5) begin #4; step(); end
    s_waitrequest = 1;
    #4;
    check("mr_pend5", pend_cnt, 5);
    check("mr_grant", grant, 2'b01);
    check("mr_wait", m0_waitrequest, 1);
    reset_n = 0; s_readdatavalid = 1;
    #1;
    check("mr_rst_grant", grant, 2'b00);
    check("mr_rst_pend", pend_cnt, 0);
    check("mr_rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    check("mr_rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    s_readdatavalid = 0;

    // Both masters stream reads: tenures of four accepts, alternating.
    do_reset();
    run_traffic(40, 100, 0, 100, 1);
    check("st_len", acc_log.size() >= 24, 1);
    for (int i = 0; i < 24 && i < acc_log.size(); i++)
      check("st_order", acc_log[i], (i / 4) % 2);
    run_traffic(60, 0, 0, 100, 0);
    check("st_drained", ret_q.size(), 0);
    check("st_m0_count", returned_rd[0], issued_rd[0]);
    check("st_m1_count", returned_rd[1], issued_rd[1]);

    // Random mixed traffic with stalls and delayed returns, then drain.
    do_reset();
    run_traffic(3000, 60, 30, 35, 0);
    run_traffic(2000, 90, 10, 60, 0);
    run_traffic(300, 0, 0, 100, 0);
    check("rnd_drained", ret_q.size(), 0);
    check("rnd_m0_count", returned_rd[0], issued_rd[0]);
    check("rnd_m1_count", returned_rd[1], issued_rd[1]);
    check("rnd_pend0", pend_cnt, 0);
    check("rnd_no_orphan", err_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
